// File: rtl/comb_pkg.sv
// Shared types and constants for the combination-engine scheduler.
package comb_pkg;

   localparam int unsigned W_ARG   = 4;
   localparam int unsigned W_RES   = 13;
   localparam int unsigned W_WDOG  = 16;
   localparam logic [15:0] TMO_DEF = 16'd4095;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ARM,
      ST_WAIT,
      ST_RESP
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_id
);

   int unsigned idx;
   logic [IW-1:0] sel;
   logic found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      sel    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         sel = IW'(idx);
         if (!found && req[sel]) begin
            found    = 1'b1;
            gnt[sel] = 1'b1;
            gnt_id   = sel;
         end
      end
   end

endmodule

// File: rtl/comb_sched.sv
// Round-robin scheduler sharing one external C(n,m) engine among NREQ requesters,
// with an m>n bypass, stale-done guard cycle and a per-job watchdog.
module comb_sched
   import comb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter logic [15:0] TMO  = TMO_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [W_ARG*NREQ-1:0]   req_m,
   input  logic [W_ARG*NREQ-1:0]   req_n,
   output logic [NREQ-1:0]         ack,
   output logic [W_RES-1:0]        result,
   output logic                    err,
   output logic                    busy,
   output logic                    eng_start,
   output logic [W_ARG-1:0]        eng_m,
   output logic [W_ARG-1:0]        eng_n,
   input  logic                    eng_done,
   input  logic [W_RES-1:0]        eng_result
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     gid_q, gid_d;
   logic [W_WDOG-1:0] wdog_q, wdog_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [W_RES-1:0]  result_q, result_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              eng_start_q, eng_start_d;
   logic [W_ARG-1:0]  eng_m_q, eng_m_d;
   logic [W_ARG-1:0]  eng_n_q, eng_n_d;

   logic [NREQ-1:0]   gnt;
   logic [IW-1:0]     gnt_id;
   logic              grant_c;
   logic [W_ARG-1:0]  m_sel_c, n_sel_c;
   logic              bypass_c;
   logic              wdog_hit_c;
   logic [NREQ-1:0]   gid_onehot_c;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign grant_c      = |gnt;
   assign m_sel_c      = req_m[W_ARG*gnt_id +: W_ARG];
   assign n_sel_c      = req_n[W_ARG*gnt_id +: W_ARG];
   assign bypass_c     = eng_m_q > eng_n_q;
   assign wdog_hit_c   = (wdog_q + 16'd1) == TMO;
   assign gid_onehot_c = NREQ'(1) << gid_q;

   // State and all registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gid_q       <= '0;
         wdog_q      <= '0;
         ack_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         eng_start_q <= 1'b0;
         eng_m_q     <= '0;
         eng_n_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gid_q       <= gid_d;
         wdog_q      <= wdog_d;
         ack_q       <= ack_d;
         result_q    <= result_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         eng_start_q <= eng_start_d;
         eng_m_q     <= eng_m_d;
         eng_n_q     <= eng_n_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_c) state_d = ST_ISSUE;
         ST_ISSUE: state_d = bypass_c ? ST_RESP : ST_ARM;
         ST_ARM:   state_d = ST_WAIT;
         ST_WAIT:  if (eng_done || wdog_hit_c) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; ack/result/err are loaded on entry to RESP
   always_comb begin
      ptr_d       = ptr_q;
      gid_d       = gid_q;
      wdog_d      = wdog_q;
      ack_d       = '0;
      result_d    = result_q;
      err_d       = err_q;
      busy_d      = state_d != ST_IDLE;
      eng_start_d = 1'b0;
      eng_m_d     = eng_m_q;
      eng_n_d     = eng_n_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_c) begin
               gid_d       = gnt_id;
               eng_m_d     = m_sel_c;
               eng_n_d     = n_sel_c;
               eng_start_d = !(m_sel_c > n_sel_c);
            end
         end
         ST_ISSUE: begin
            wdog_d = '0;
            if (bypass_c) begin
               result_d = '0;
               err_d    = 1'b0;
               ack_d    = gid_onehot_c;
            end
         end
         ST_WAIT: begin
            wdog_d = wdog_q + 16'd1;
            if (eng_done) begin
               result_d = eng_result;
               err_d    = 1'b0;
               ack_d    = gid_onehot_c;
            end else if (wdog_hit_c) begin
               result_d = '0;
               err_d    = 1'b1;
               ack_d    = gid_onehot_c;
            end
         end
         ST_RESP: begin
            if (32'(gid_q) == NREQ - 1) ptr_d = '0;
            else                        ptr_d = gid_q + IW'(1);
         end
         default: ;
      endcase
   end

   assign ack       = ack_q;
   assign result    = result_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign eng_start = eng_start_q;
   assign eng_m     = eng_m_q;
   assign eng_n     = eng_n_q;

endmodule

// File: tb/tb_comb_sched.sv
// Directed bench for comb_sched: single job, bypass, contention, stale done, watchdog, reset abort.
module tb_comb_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_m, req_n;
   logic [3:0]  ack;
   logic [12:0] result;
   logic        err, busy, eng_start;
   logic [3:0]  eng_m, eng_n;
   logic        eng_done;
   logic [12:0] eng_result;

   int checks   = 0;
   int failures = 0;
   int n;

   always #5 clk = ~clk;

   comb_sched #(.NREQ(4), .TMO(16'd100)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_m      (req_m),
      .req_n      (req_n),
      .ack        (ack),
      .result     (result),
      .err        (err),
      .busy       (busy),
      .eng_start  (eng_start),
      .eng_m      (eng_m),
      .eng_n      (eng_n),
      .eng_done   (eng_done),
      .eng_result (eng_result)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] m, input logic [3:0] nn);
      req[i]          = 1'b1;
      req_m[i*4 +: 4] = m;
      req_n[i*4 +: 4] = nn;
   endtask

   task automatic wait_start(output int cnt);
      cnt = 0;
      while (eng_start !== 1'b1 && cnt < 50) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_ack(output int cnt, input int limit);
      cnt = 0;
      while (ack === 4'b0000 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b0; req = '0; req_m = '0; req_n = '0;
      eng_done = 1'b0; eng_result = '0;
      tick(); tick(); tick();
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_err_busy_start", 32'({err, busy, eng_start}), 32'(0));
      check("rst_eng_mn", 32'({eng_m, eng_n}), 32'(0));
      rst = 1'b1;
      tick();

      // Single engine job: C(5,2)=10
      set_req(0, 4'd2, 4'd5);
      wait_start(n);
      check("t1_start_lat", 32'(n), 32'(1));
      check("t1_eng_mn", 32'({eng_m, eng_n}), 32'(8'h25));
      check("t1_busy", 32'(busy), 32'(1));
      tick();
      check("t1_start_pulse", 32'(eng_start), 32'(0));
      repeat (19) tick();
      check("t1_no_early_ack", 32'(ack), 32'(0));
      eng_result = 13'd10; eng_done = 1'b1;
      tick();
      check("t1_ack", 32'(ack), 32'(4'b0001));
      check("t1_result", 32'(result), 32'(10));
      check("t1_err", 32'(err), 32'(0));
      req = '0; eng_done = 1'b0;
      tick();
      check("t1_ack_pulse", 32'(ack), 32'(0));
      check("t1_idle", 32'(busy), 32'(0));

      // Bypass m>n: no engine start, ack 2 cycles after grant
      set_req(1, 4'd6, 4'd3);
      tick();
      check("t2_no_start", 32'(eng_start), 32'(0));
      check("t2_no_ack_yet", 32'(ack), 32'(0));
      check("t2_eng_mn", 32'({eng_m, eng_n}), 32'(8'h63));
      tick();
      check("t2_ack", 32'(ack), 32'(4'b0010));
      check("t2_result_err", 32'({err, result}), 32'(0));
      req = '0;
      tick();
      check("t2_ack_pulse", 32'(ack), 32'(0));

      // Clear ptr back to 0 via reset
      rst = 1'b0; tick(); rst = 1'b1; tick();

      // Contention: req0 and req2 together, each C(4,4)=1
      set_req(0, 4'd4, 4'd4); set_req(2, 4'd4, 4'd4);
      wait_start(n);
      check("t3_start0_lat", 32'(n), 32'(1));
      tick(); tick();
      eng_result = 13'd1; eng_done = 1'b1;
      tick();
      check("t3_ack0", 32'(ack), 32'(4'b0001));
      check("t3_result0", 32'(result), 32'(1));
      req[0] = 1'b0; eng_done = 1'b0;
      tick();
      wait_start(n);
      check("t3_start2_lat", 32'(n), 32'(1));
      tick(); tick();
      eng_done = 1'b1;
      tick();
      check("t3_ack2", 32'(ack), 32'(4'b0100));
      check("t3_result2", 32'(result), 32'(1));
      req[2] = 1'b0;
      tick();

      // ptr must now be 3: req0 and req3 bypass jobs, req3 served first
      set_req(0, 4'd9, 4'd2); set_req(3, 4'd9, 4'd2);
      tick(); tick();
      check("t4_ack3_first", 32'(ack), 32'(4'b1000));
      req[3] = 1'b0;
      tick(); tick(); tick();
      check("t4_ack0_second", 32'(ack), 32'(4'b0001));
      req = '0;
      tick();

      // Stale done still high from the earlier job, old result 1
      set_req(1, 4'd3, 4'd5);
      wait_start(n);
      check("t5_start_lat", 32'(n), 32'(1));
      tick(); tick();
      check("t5_arm_ignores_done", 32'(ack), 32'(0));
      eng_done = 1'b0; eng_result = 13'd10;
      tick();
      check("t5_wait_no_ack", 32'(ack), 32'(0));
      eng_done = 1'b1;
      tick();
      check("t5_ack", 32'(ack), 32'(4'b0010));
      check("t5_result_new", 32'(result), 32'(10));
      req = '0; eng_done = 1'b0;
      tick();

      // Watchdog: TMO=100, engine never finishes
      set_req(2, 4'd1, 4'd2);
      wait_start(n);
      check("t6_start_lat", 32'(n), 32'(1));
      wait_ack(n, 300);
      check("t6_timeout_lat", 32'(n), 32'(102));
      check("t6_ack", 32'(ack), 32'(4'b0100));
      check("t6_err", 32'(err), 32'(1));
      check("t6_result", 32'(result), 32'(0));
      req = '0;
      tick();

      // Reset while in WAIT aborts the job
      set_req(0, 4'd2, 4'd4);
      wait_start(n);
      check("t7_start_lat", 32'(n), 32'(1));
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      check("t7_rst_ack_busy", 32'({ack, busy, eng_start}), 32'(0));
      check("t7_rst_eng_mn", 32'({eng_m, eng_n}), 32'(0));
      check("t7_rst_result_err", 32'({err, result}), 32'(0));
      rst = 1'b1; req = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t7_quiet", 32'({ack, eng_start, busy}), 32'(0));
      end
      set_req(3, 4'd5, 4'd5);
      wait_start(n);
      check("t7_new_start_lat", 32'(n), 32'(1));
      tick(); tick();
      eng_result = 13'd1; eng_done = 1'b1;
      tick();
      check("t7_ack3", 32'(ack), 32'(4'b1000));
      check("t7_result3", 32'(result), 32'(1));
      req = '0; eng_done = 1'b0;
      tick();
      check("t7_idle", 32'({busy, ack}), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
